// File: rtl/hilo_div_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
//   master (EX side): drives signed_div_i, opdata1_i, opdata2_i, start_i, annul_i;
//                     observes result_o, ready_o.
//   slave (divider):  the mirror image.
// result_o is packed {remainder, quotient} and is meaningful only while ready_o = 1.
interface hilo_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/hilo_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - hilo_div_unit_if.slave: signed_div_i, opdata1_i (dividend), opdata2_i (divisor),
//          start_i, annul_i in; result_o = {remainder, quotient}, ready_o out (registered).
// Divides magnitudes and applies the sign fix on the final iteration: quotient negated when
// operand signs differ, remainder takes the dividend's sign.
module hilo_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  hilo_div_unit_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               fits;
  logic               last_iter;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // State register, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFree;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      ready_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      ready_q    <= ready_d;
      result_q   <= result_d;
    end
  end

  // Next state and datapath
  always_comb begin
    // Partial remainder is WIDTH+1 bits after the shift; the difference always fits in WIDTH.
    shifted    = {rem_q, dvd_q[WIDTH-1]};
    fits       = (shifted >= {1'b0, dvs_q});
    diff       = shifted[WIDTH-1:0] - dvs_q;
    last_iter  = (cnt_q == CntW'(WIDTH - 1));
    neg1       = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    neg2       = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    abs1       = neg1 ? -bus.opdata1_i : bus.opdata1_i;
    abs2       = neg2 ? -bus.opdata2_i : bus.opdata2_i;

    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;

    case (state_q)
      StFree: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = StByZero;
          end else begin
            state_d    = StOn;
            cnt_d      = '0;
            rem_d      = '0;
            dvd_d      = abs1;
            dvs_d      = abs2;
            quot_neg_d = neg1 ^ neg2;
            rem_neg_d  = neg1;
          end
        end
      end
      StByZero: state_d = bus.annul_i ? StFree : StEnd;
      StOn: begin
        if (bus.annul_i) begin
          state_d = StFree;
        end else begin
          rem_d = fits ? diff : shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], fits};
          cnt_d = cnt_q + 1'b1;
          if (last_iter) state_d = StEnd;
        end
      end
      StEnd: begin
        if (bus.annul_i || !bus.start_i) state_d = StFree;
      end
      default: state_d = StFree;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    quot_fix = quot_neg_q ? -dvd_d : dvd_d;
    rem_fix  = rem_neg_q ? -rem_d : rem_d;
    ready_d  = 1'b0;
    result_d = '0;
    case (state_q)
      StByZero: ready_d = !bus.annul_i;
      StOn: begin
        if (!bus.annul_i && last_iter) begin
          ready_d  = 1'b1;
          result_d = {rem_fix, quot_fix};
        end
      end
      StEnd: begin
        if (!bus.annul_i && bus.start_i) begin
          ready_d  = ready_q;
          result_d = result_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
module tb_hilo_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  hilo_div_unit_if #(.WIDTH(32)) bus ();

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request on a falling edge, expect ready_o exactly after edge lat, check
  // the result, its stability while start_i is held, and the return to idle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    logic early;
    early = 1'b0;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) early = 1'b1;
      // Operands must be ignored once accepted.
      bus.opdata1_i = 32'hDEAD_BEEF;
      bus.opdata2_i = 32'h0000_0005;
    end
    check({tag, "_early"}, {63'd0, early}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_ready"}, {63'd0, bus.ready_o}, 64'd1);
    check({tag, "_result"}, bus.result_o, exp);
    @(posedge clk); #1;
    check({tag, "_hold"}, bus.result_o, exp);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop"}, {63'd0, bus.ready_o}, 64'd0);
  endtask

  task automatic watch_idle(input string tag, input int n);
    logic rose;
    rose = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) rose = 1'b1;
    end
    check(tag, {63'd0, rose}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1;
    check("rst_ready", {63'd0, bus.ready_o}, 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div("divu_7_2",    1'b0, 32'd7,        32'd2,        {32'h1, 32'h3}, 33);
    run_div("div_m7_2",    1'b1, 32'hFFFFFFF9, 32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div("div_7_m2",    1'b1, 32'h7,        32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33);
    run_div("div_m8_m3",   1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, {32'hFFFFFFFE, 32'h2}, 33);
    run_div("divu_max_1",  1'b0, 32'hFFFFFFFF, 32'h1,        {32'h0, 32'hFFFFFFFF}, 33);
    run_div("div_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    run_div("divu_big",    1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33);
    run_div("div_by_zero", 1'b1, 32'h1234,     32'h0,        64'd0, 2);

    // annul_i in FREE blocks acceptance (a divide-by-zero would otherwise finish in 2 edges)
    @(negedge clk);
    bus.opdata1_i = 32'd5;
    bus.opdata2_i = 32'd0;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    watch_idle("annul_free", 6);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    // annul_i at iteration 10 aborts; no result ever appears
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check("annul_on_ready", {63'd0, bus.ready_o}, 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    watch_idle("annul_on_idle", 40);
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);

    // Async reset while holding a finished result
    @(negedge clk);
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    check("pre_rst_ready", {63'd0, bus.ready_o}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_end_ready", {63'd0, bus.ready_o}, 64'd0);
    check("rst_end_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;

    // Async reset mid-ON, then a full request
    @(negedge clk);
    bus.start_i = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_on_ready", {63'd0, bus.ready_o}, 64'd0);
    check("rst_on_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    watch_idle("rst_on_idle", 36);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
